load_store_unit: RTL and testbench

- Consumer end of the EX -> LSU interface. Takes one execution-stage result per accepted cycle and either retires it directly to register writeback or runs it as a data-memory load/store on a req/gnt/rvalid bus.
- Performs byte-lane steering, load sign/zero extension and alignment checking.
- Back-pressures the pipeline with o_stall while a memory transaction is outstanding.

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: retires EX results to writeback or runs them as aligned loads/stores on a req/gnt/rvalid bus
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_is_reg_write,
  input  logic        i_is_mem_read,
  input  logic        i_is_mem_write,
  input  logic [31:0] i_mem_address,
  input  logic [4:0]  i_rd_id,
  input  logic [31:0] i_mem_data,
  input  logic [31:0] i_reg_data,
  input  logic [2:0]  i_mem_funct3,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_enable,
  output logic [4:0]  o_wb_rd_id,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned,
  output logic        o_bus_error
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_e;
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, wb_data_q, wb_data_d, cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic        st_q, st_d, wb_en_q, wb_en_d, mis_q, mis_d, berr_q, berr_d;
  logic        mis, timeout;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wd, shifted, ld_val;
  // funct3[1:0] encodes size (00 byte, 01 half, else word); bit 2 selects zero extension
  assign mis     = i_mem_funct3[1:0] == 2'b00 ? 1'b0 :
                   i_mem_funct3[1:0] == 2'b01 ? i_mem_address[0] : |i_mem_address[1:0];
  assign timeout = TIMEOUT_CYCLES != 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1);
  assign off     = addr_q[1:0];
  assign shifted = i_dmem_rdata >> {off, 3'b000};
  assign ld_val  = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]} :
                   f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} : i_dmem_rdata;
  assign be      = !st_q ? 4'hF : f3_q[1:0] == 2'b00 ? 4'b0001 << off :
                   f3_q[1:0] == 2'b01 ? 4'b0011 << off : 4'hF;
  assign wd      = f3_q[1:0] == 2'b00 ? {4{data_q[7:0]}} :
                   f3_q[1:0] == 2'b01 ? {2{data_q[15:0]}} : data_q;
  assign o_stall      = state_q != IDLE;
  assign o_dmem_req   = state_q == REQ;
  assign o_dmem_we    = o_dmem_req & st_q;
  assign o_dmem_addr  = o_dmem_req ? {addr_q[31:2], 2'b00} : '0;
  assign o_dmem_be    = o_dmem_req ? be : '0;
  assign o_dmem_wdata = o_dmem_req ? wd : '0;
  assign o_wb_enable  = wb_en_q;
  assign o_wb_rd_id   = wb_rd_q;
  assign o_wb_data    = wb_data_q;
  assign o_misaligned = mis_q;
  assign o_bus_error  = berr_q;
  // next state: accept in IDLE, hold request until grant, wait for read data, abort on timeout
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    st_d      = st_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    case (state_q)
      IDLE: if (i_valid) begin
        if (i_is_mem_read || i_is_mem_write) begin
          if (mis) mis_d = 1'b1;
          else begin
            state_d = REQ;
            addr_d  = i_mem_address;
            data_d  = i_mem_data;
            f3_d    = i_mem_funct3;
            rd_d    = i_rd_id;
            st_d    = ~i_is_mem_read;
          end
        end else if (i_is_reg_write) begin
          wb_en_d   = |i_rd_id;
          wb_rd_d   = i_rd_id;
          wb_data_d = i_reg_data;
        end
      end
      REQ: if (i_dmem_gnt) state_d = st_q ? IDLE : WAIT_RESP;
      else if (timeout) begin
        state_d = IDLE;
        berr_d  = 1'b1;
      end
      WAIT_RESP: if (i_dmem_rvalid) begin
        state_d   = IDLE;
        wb_en_d   = |rd_q;
        wb_rd_d   = rd_q;
        wb_data_d = ld_val;
      end else if (timeout) begin
        state_d = IDLE;
        berr_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // timeout counter restarts on every state change and sits at zero in IDLE
  assign cnt_d = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 32'd1;
  // state and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      st_q      <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      st_q      <= st_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed transactions checked every cycle against a transaction-level model
module tb_load_store_unit;
  localparam int TO = 4;
  logic        i_clk = 0, i_rst_n = 0;
  logic        i_valid = 0, i_is_reg_write = 0, i_is_mem_read = 0, i_is_mem_write = 0;
  logic [31:0] i_mem_address = 0, i_mem_data = 0, i_reg_data = 0, i_dmem_rdata = 0;
  logic [4:0]  i_rd_id = 0;
  logic [2:0]  i_mem_funct3 = 0;
  logic        i_dmem_gnt = 0, i_dmem_rvalid = 0;
  logic        o_stall, o_dmem_req, o_dmem_we, o_wb_enable, o_misaligned, o_bus_error;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_wb_rd_id;
  int n_vec = 0, n_bad = 0;
  logic        e_stall = 0, e_req = 0, e_we = 0, e_wb_en = 0, e_mis = 0, e_berr = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_wb_data = 0;
  logic [3:0]  e_be = 0;
  logic [4:0]  e_wb_rd = 0;
  logic        n_wb_en = 0, n_mis = 0, n_berr = 0;
  logic [4:0]  n_wb_rd = 0;
  logic [31:0] n_wb_data = 0;
  bit          in_rst = 1;

  always #5 i_clk = ~i_clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_is_reg_write(i_is_reg_write),
    .i_is_mem_read(i_is_mem_read), .i_is_mem_write(i_is_mem_write), .i_mem_address(i_mem_address),
    .i_rd_id(i_rd_id), .i_mem_data(i_mem_data), .i_reg_data(i_reg_data), .i_mem_funct3(i_mem_funct3),
    .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata), .o_wb_enable(o_wb_enable),
    .o_wb_rd_id(o_wb_rd_id), .o_wb_data(o_wb_data), .o_misaligned(o_misaligned),
    .o_bus_error(o_bus_error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // access size in bytes
  function automatic int sz(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n = sz(f3);
    if (!st) return 4'hF;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = sz(f3);
    if (n == 1) return {24'b0, d[7:0]} * 32'h01010101;
    if (n == 2) return {16'b0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [2:0] f3, input logic [31:0] a);
    int n = sz(f3);
    logic [31:0] v, lim;
    if (n == 4) return rd;
    v   = rd >> (8 * (a % 4));
    lim = 32'd1 << (8 * n);
    v   = v % lim;
    if (!f3[2] && v >= (lim >> 1)) v = v - lim;
    return v;
  endfunction

  // every cycle: outputs against the model's expectations for that cycle
  always @(negedge i_clk) begin
    if (in_rst) begin
      chk("rst_stall", o_stall, 0); chk("rst_req", o_dmem_req, 0); chk("rst_we", o_dmem_we, 0);
      chk("rst_addr", o_dmem_addr, 0); chk("rst_be", o_dmem_be, 0); chk("rst_wdata", o_dmem_wdata, 0);
      chk("rst_wb_en", o_wb_enable, 0); chk("rst_wb_rd", o_wb_rd_id, 0); chk("rst_wb_data", o_wb_data, 0);
      chk("rst_mis", o_misaligned, 0); chk("rst_berr", o_bus_error, 0);
    end else begin
      chk("stall", o_stall, e_stall); chk("req", o_dmem_req, e_req); chk("wb_en", o_wb_enable, e_wb_en);
      chk("misaligned", o_misaligned, e_mis); chk("bus_error", o_bus_error, e_berr);
      if (e_req) begin
        chk("we", o_dmem_we, e_we); chk("addr", o_dmem_addr, e_addr); chk("be", o_dmem_be, e_be);
        if (e_we) chk("wdata", o_dmem_wdata, e_wdata);
      end
      if (e_wb_en) begin
        chk("wb_rd", o_wb_rd_id, e_wb_rd); chk("wb_data", o_wb_data, e_wb_data);
      end
    end
  end

  task automatic step();
    @(posedge i_clk); #2;
    e_wb_en = n_wb_en; e_wb_rd = n_wb_rd; e_wb_data = n_wb_data; e_mis = n_mis; e_berr = n_berr;
    n_wb_en = 0; n_mis = 0; n_berr = 0;
    e_stall = 0; e_req = 0; e_we = 0;
    i_valid = 0; i_is_reg_write = 0; i_is_mem_read = 0; i_is_mem_write = 0;
    i_dmem_gnt = 0; i_dmem_rvalid = 0;
  endtask

  // an upstream op offered while stalled must be ignored
  task automatic junk();
    i_valid = 1; i_is_reg_write = 1; i_rd_id = 31; i_reg_data = 32'h5A5A5A5A;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    step();
    i_valid = 1; i_is_reg_write = 1; i_rd_id = rd; i_reg_data = d;
    n_wb_en = (rd != 0); n_wb_rd = rd; n_wb_data = d;
  endtask

  // gd/rv: cycles of wait before gnt / rvalid (-1 = never)
  task automatic mem(input bit ld, input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                     input logic [31:0] d, input int gd, input int rv, input logic [31:0] rdata);
    step();
    i_valid = 1; i_is_mem_read = ld; i_is_mem_write = 1; i_is_reg_write = 1; i_reg_data = 32'hBAD0BAD0;
    i_rd_id = rd; i_mem_address = a; i_mem_funct3 = f3; i_mem_data = d;
    if ((a % sz(f3)) != 0) begin n_mis = 1; return; end
    for (int k = 0; ; k++) begin
      step();
      e_stall = 1; e_req = 1; e_we = !ld; e_addr = {a[31:2], 2'b00}; e_be = m_be(!ld, f3, a); e_wdata = m_wdata(f3, d);
      junk(); i_dmem_rvalid = 1; i_dmem_rdata = 32'hFFFFFFFF;
      if (k == gd) begin i_dmem_gnt = 1; break; end
      if (k == TO - 1) begin n_berr = 1; return; end
    end
    if (!ld) return;
    for (int j = 0; ; j++) begin
      step();
      e_stall = 1; junk();
      if (j == rv) begin
        i_dmem_rvalid = 1; i_dmem_rdata = rdata;
        n_wb_en = (rd != 0); n_wb_rd = rd; n_wb_data = m_load(rdata, f3, a);
        break;
      end
      if (j == TO - 1) begin n_berr = 1; return; end
    end
  endtask

  task automatic rst_mid(input bit in_wait);
    step();
    i_valid = 1; i_is_mem_read = 1; i_mem_funct3 = 3'b010; i_mem_address = 32'h8000; i_rd_id = 4;
    step();
    e_stall = 1; e_req = 1; e_addr = 32'h8000; e_be = 4'hF; i_dmem_gnt = in_wait;
    if (in_wait) begin step(); e_stall = 1; end
    #1; i_rst_n = 0; in_rst = 1; n_wb_en = 0; n_mis = 0; n_berr = 0;
    #1;
    chk("rst_async_stall", o_stall, 0); chk("rst_async_req", o_dmem_req, 0);
    step(); step();
    i_rst_n = 1; in_rst = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'h12345678;
    step(); i_dmem_rvalid = 1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    chk("pin_lb", m_load(32'h80FF0000, 3'b000, 32'h1003), 32'hFFFFFF80);
    chk("pin_sh_be", m_be(1, 3'b001, 32'h2002), 4'b1100);
    chk("pin_sh_wd", m_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    chk("pin_lhu", m_load(32'hBEEF1234, 3'b101, 32'h3002), 32'h0000BEEF);
    chk("pin_lh", m_load(32'h80010000, 3'b001, 32'h4002), 32'hFFFF8001);
    chk("pin_sb_be", m_be(1, 3'b000, 32'h5001), 4'b0010);
    repeat (3) @(posedge i_clk);
    #2; i_rst_n = 1; in_rst = 0;
    wr(5, 32'hDEADBEEF);
    step();
    chk("lit_wr_data", o_wb_data, 32'hDEADBEEF);
    mem(1, 3'b000, 32'h1003, 7, 0, 2, 0, 32'h80FF0000);
    step();
    #2 chk("lit_lb_data", o_wb_data, 32'hFFFFFF80);
    mem(0, 3'b001, 32'h2002, 0, 32'h1234ABCD, 0, 0, 0);
    step();
    mem(1, 3'b010, 32'h3001, 8, 0, 0, 0, 0);
    step();
    mem(1, 3'b101, 32'h3002, 0, 0, 1, 1, 32'hBEEF1234);
    step();
    mem(1, 3'b010, 32'h3100, 9, 0, -1, 0, 0);
    step(); step();
    mem(1, 3'b001, 32'h4002, 3, 0, 0, 2, 32'h80010000);
    wr(9, 32'h00000011);
    step();
    mem(0, 3'b000, 32'h5001, 0, 32'h000000A5, 3, 0, 0);
    mem(0, 3'b010, 32'h5004, 0, 32'hCAFEF00D, 1, 0, 0);
    mem(0, 3'b001, 32'h5001, 0, 32'h1111, 0, 0, 0);
    mem(1, 3'b100, 32'h6002, 10, 0, 0, 0, 32'h00F00000);
    mem(1, 3'b010, 32'h7000, 11, 0, 1, 3, 32'h12345678);
    mem(1, 3'b011, 32'h7002, 12, 0, 0, 0, 0);
    mem(1, 3'b110, 32'h7008, 13, 0, 0, 0, 32'h87654321);
    mem(1, 3'b001, 32'h4003, 14, 0, 0, 0, 0);
    wr(0, 32'h77777777);
    wr(1, 32'h00000000);
    step();
    rst_mid(1);
    rst_mid(0);
    wr(6, 32'hA5A5A5A5);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
